// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite slave endpoint with a bank of REG_NUM
// software-visible 32-bit registers. The write channels are buffered
// independently, and byte strobes are applied when a write commits.
// Every register is exported in parallel on reg_out.
// Optional feature macro: AXI_REGS_SLVERR_EN. When it is defined, an access
// with addr[1:0] != 0 is answered with SLVERR and has no effect on the registers.
module axi4_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         s_awaddr,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [DATA_WIDTH-1:0]         s_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_wstrb,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  input  logic [ADDR_WIDTH-1:0]         s_araddr,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_out
);

  localparam int IDX_W  = $clog2(REG_NUM);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REG_NUM];

  logic                  awFull_q;
  logic [IDX_W-1:0]      awIdx_q;
  logic                  wFull_q;
  logic [DATA_WIDTH-1:0] wData_q;
  logic [STRB_W-1:0]     wStrb_q;
  logic                  bValid_q;
  logic                  rValid_q;
  logic [DATA_WIDTH-1:0] rData_q;

  logic                  awHs;
  logic                  wHs;
  logic                  arHs;
  logic                  commit;
  logic                  writeEnable;
  logic [IDX_W-1:0]      awIdxIn;
  logic [IDX_W-1:0]      arIdxIn;
  logic [IDX_W-1:0]      commitIdx;
  logic [DATA_WIDTH-1:0] commitData;
  logic [STRB_W-1:0]     commitStrb;

  // The ready outputs depend only on the buffer and response state, so
  // they never combinationally follow the valid inputs.
  assign s_awready = !awFull_q && !bValid_q;
  assign s_wready  = !wFull_q && !bValid_q;
  assign s_arready = !rValid_q;

  assign awHs = s_awvalid && s_awready;
  assign wHs  = s_wvalid && s_wready;
  assign arHs = s_arvalid && s_arready;

  // Addresses alias across the decoded window because only the index
  // bits select a register.
  assign awIdxIn = s_awaddr[IDX_W+1:2];
  assign arIdxIn = s_araddr[IDX_W+1:2];

  // A write commits as soon as address and data are both available. Each
  // of them can come from its buffer or from a handshake in this cycle.
  assign commit     = (awFull_q || awHs) && (wFull_q || wHs);
  assign commitIdx  = awFull_q ? awIdx_q : awIdxIn;
  assign commitData = wFull_q ? wData_q : s_wdata;
  assign commitStrb = wFull_q ? wStrb_q : s_wstrb;

`ifdef AXI_REGS_SLVERR_EN
  logic       awErr_q;
  logic       awErrIn;
  logic       arErrIn;
  logic       commitErr;
  logic [1:0] bResp_q;
  logic [1:0] rResp_q;
  logic       unusedAddr;

  assign awErrIn     = (s_awaddr[1:0] != 2'b00);
  assign arErrIn     = (s_araddr[1:0] != 2'b00);
  assign commitErr   = awFull_q ? awErr_q : awErrIn;
  assign writeEnable = commit && !commitErr;
  assign s_bresp     = bResp_q;
  assign s_rresp     = rResp_q;
  assign unusedAddr  = ^{s_awaddr[ADDR_WIDTH-1:IDX_W+2], s_araddr[ADDR_WIDTH-1:IDX_W+2]};

  // The misalignment flag of a buffered address travels with that address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awErr_q <= 1'b0;
    end else if (awHs && !commit) begin
      awErr_q <= awErrIn;
    end
  end

  // The write response code is captured at commit and held until the B handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bResp_q <= 2'b00;
    end else if (commit) begin
      bResp_q <= commitErr ? 2'b10 : 2'b00;
    end
  end

  // The read response code is captured on the AR handshake, together with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rResp_q <= 2'b00;
    end else if (arHs) begin
      rResp_q <= arErrIn ? 2'b10 : 2'b00;
    end
  end
`else
  logic unusedAddr;

  assign writeEnable = commit;
  assign s_bresp     = 2'b00;
  assign s_rresp     = 2'b00;
  assign unusedAddr  = ^{s_awaddr[ADDR_WIDTH-1:IDX_W+2], s_awaddr[1:0],
                         s_araddr[ADDR_WIDTH-1:IDX_W+2], s_araddr[1:0]};
`endif

  // The AW buffer holds an address that arrived before its data. It is
  // emptied by the commit that consumes the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awFull_q <= 1'b0;
      awIdx_q  <= '0;
    end else if (commit) begin
      awFull_q <= 1'b0;
    end else if (awHs) begin
      awFull_q <= 1'b1;
      awIdx_q  <= awIdxIn;
    end
  end

  // The W buffer holds data and strobes that arrived before their address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wFull_q <= 1'b0;
      wData_q <= '0;
      wStrb_q <= '0;
    end else if (commit) begin
      wFull_q <= 1'b0;
    end else if (wHs) begin
      wFull_q <= 1'b1;
      wData_q <= s_wdata;
      wStrb_q <= s_wstrb;
    end
  end

  // Strobe merge: enabled bytes take the new data and all other bytes keep their value.
  always_comb begin
    regs_d = regs_q;
    if (writeEnable) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (commitStrb[b]) begin
          regs_d[commitIdx][8*b +: 8] = commitData[8*b +: 8];
        end
      end
    end
  end

  // The register bank is cleared by reset and otherwise follows the merged next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // B valid rises at commit and stays high until the master accepts the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bValid_q <= 1'b0;
    end else if (commit) begin
      bValid_q <= 1'b1;
    end else if (bValid_q && s_bready) begin
      bValid_q <= 1'b0;
    end
  end

  // Read data is taken from the current register state. A write that
  // commits on the same edge is therefore not visible in this read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rValid_q <= 1'b0;
      rData_q  <= '0;
    end else if (arHs) begin
      rValid_q <= 1'b1;
`ifdef AXI_REGS_SLVERR_EN
      rData_q  <= arErrIn ? '0 : regs_q[arIdxIn];
`else
      rData_q  <= regs_q[arIdxIn];
`endif
    end else if (rValid_q && s_rready) begin
      rValid_q <= 1'b0;
    end
  end

  assign s_bvalid = bValid_q;
  assign s_rvalid = rValid_q;
  assign s_rdata  = rData_q;

  for (genvar i = 0; i < REG_NUM; i++) begin : g_regOut
    assign reg_out[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// tb_axi4_lite_slave_regs: self-checking bench for axi4_lite_slave_regs.
// Random and directed traffic is compared against a behavioural register model.
// Honours AXI_REGS_SLVERR_EN when the bench is built with that macro.
module tb_axi4_lite_slave_regs;

  localparam int REG_NUM = 8;

  logic                  clk;
  logic                  rst_n;
  logic [31:0]           s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [31:0]           s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [REG_NUM*32-1:0] reg_out;

  int checkCount;
  int errorCount;

  logic [31:0] model [REG_NUM];

  axi4_lite_slave_regs #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .REG_NUM(REG_NUM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_awaddr(s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata(s_wdata),
    .s_wstrb(s_wstrb),
    .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp),
    .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .s_araddr(s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata(s_rdata),
    .s_rresp(s_rresp),
    .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .reg_out(reg_out)
  );

  // 100 MHz clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register index as the address decoder sees it: the word address modulo the bank size.
  function automatic int idxOf(input logic [31:0] addr);
    return int'((addr / 4) % REG_NUM);
  endfunction

  // Model of a committed write: each byte whose strobe bit is set takes the new value.
  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = idxOf(addr);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] regOf(input int i);
    return reg_out[32*i +: 32];
  endfunction

  task automatic driveAw(input logic [31:0] addr, input int delay);
    logic rdy;
    repeat (delay) tick();
    s_awaddr  = addr;
    s_awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      rdy = s_awready;
      tick();
      if (rdy) begin
        s_awvalid = 1'b0;
        return;
      end
    end
    s_awvalid = 1'b0;
    checkCount++;
    errorCount++;
    $display("[TB] FAIL awTimeout: awready still %0b after 50 cycles, required 1", s_awready);
  endtask

  task automatic driveW(input logic [31:0] data, input logic [3:0] strb, input int delay);
    logic rdy;
    repeat (delay) tick();
    s_wdata  = data;
    s_wstrb  = strb;
    s_wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      rdy = s_wready;
      tick();
      if (rdy) begin
        s_wvalid = 1'b0;
        return;
      end
    end
    s_wvalid = 1'b0;
    checkCount++;
    errorCount++;
    $display("[TB] FAIL wTimeout: wready still %0b after 50 cycles, required 1", s_wready);
  endtask

  // Full write transaction with bready held high; returns the B response code.
  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDelay, input int wDelay, output logic [1:0] resp);
    s_bready = 1'b1;
    fork
      driveAw(addr, awDelay);
      driveW(data, strb, wDelay);
    join
    for (int n = 0; n < 20 && !s_bvalid; n++) tick();
    if (!s_bvalid) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL bTimeout: bvalid %0b, required 1", s_bvalid);
    end
    resp = s_bresp;
    tick();
  endtask

  // Full read transaction with rready held high.
  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic rdy;
    logic done;
    done      = 1'b0;
    s_rready  = 1'b1;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      rdy = s_arready;
      tick();
      if (rdy) done = 1'b1;
    end
    s_arvalid = 1'b0;
    if (!done || !s_rvalid) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL rTimeout: arHandshake %0b rvalid %0b, required 1 and 1", done, s_rvalid);
    end
    data = s_rdata;
    resp = s_rresp;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    for (int i = 0; i < REG_NUM; i++) model[i] = '0;
    repeat (3) tick();
    checkCount++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errorCount++;
      $display("[TB] FAIL resetReady: aw/w/ar ready %b, required 111", {s_awready, s_wready, s_arready});
    end
    checkCount++;
    if ({s_bvalid, s_rvalid, s_bresp, s_rresp} !== 6'b0) begin
      errorCount++;
      $display("[TB] FAIL resetResp: bvalid %b rvalid %b bresp %b rresp %b, required all 0",
               s_bvalid, s_rvalid, s_bresp, s_rresp);
    end
    checkCount++;
    if (s_rdata !== 32'h0 || reg_out !== '0) begin
      errorCount++;
      $display("[TB] FAIL resetData: rdata %h reg_out %h, required 0", s_rdata, reg_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous_write();
    s_bready  = 1'b1;
    s_awaddr  = 32'h0000_000C;
    s_awvalid = 1'b1;
    s_wdata   = 32'hDEAD_BEEF;
    s_wstrb   = 4'hF;
    s_wvalid  = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    modelWrite(32'h0C, 32'hDEAD_BEEF, 4'hF);
    checkCount++;
    if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
      errorCount++;
      $display("[TB] FAIL simWriteB: bvalid %b bresp %b, required 1 00", s_bvalid, s_bresp);
    end
    checkCount++;
    if (reg_out[127:96] !== model[3]) begin
      errorCount++;
      $display("[TB] FAIL simWriteReg: reg3 %h, required %h", reg_out[127:96], model[3]);
    end
    tick();
    checkCount++;
    if (s_bvalid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL simWriteBPulse: bvalid %b, required 0", s_bvalid);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    axiWrite(32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    modelWrite(32'h04, 32'hFFFF_FFFF, 4'hF);
    s_wdata  = 32'h1122_3344;
    s_wstrb  = 4'b0101;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    checkCount++;
    if (s_wready !== 1'b0 || s_bvalid !== 1'b0 || regOf(1) !== 32'hFFFF_FFFF) begin
      errorCount++;
      $display("[TB] FAIL wBuffered: wready %b bvalid %b reg1 %h, required 0 0 ffffffff",
               s_wready, s_bvalid, regOf(1));
    end
    repeat (2) tick();
    s_awaddr  = 32'h04;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    modelWrite(32'h04, 32'h1122_3344, 4'b0101);
    checkCount++;
    if (s_bvalid !== 1'b1 || regOf(1) !== 32'hFF22_FF44 || model[1] !== 32'hFF22_FF44) begin
      errorCount++;
      $display("[TB] FAIL wBeforeAwCommit: bvalid %b reg1 %h, required 1 ff22ff44", s_bvalid, regOf(1));
    end
    tick();
  endtask

  task automatic test_bready_stall();
    logic [31:0] d1;
    logic [31:0] d2;
    logic        stallBad;
    d1 = $urandom;
    d2 = $urandom;
    stallBad  = 1'b0;
    s_bready  = 1'b0;
    s_awaddr  = 32'h08;
    s_awvalid = 1'b1;
    s_wdata   = d1;
    s_wstrb   = 4'hF;
    s_wvalid  = 1'b1;
    tick();
    s_wvalid = 1'b0;
    modelWrite(32'h08, d1, 4'hF);
    s_awaddr = 32'h14;
    for (int c = 0; c < 5; c++) begin
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_awready !== 1'b0 || s_wready !== 1'b0)
        stallBad = 1'b1;
      tick();
    end
    checkCount++;
    if (stallBad) begin
      errorCount++;
      $display("[TB] FAIL bStall: bvalid %b bresp %b awready %b wready %b, required 1 00 0 0",
               s_bvalid, s_bresp, s_awready, s_wready);
    end
    s_bready = 1'b1;
    tick();
    checkCount++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || regOf(2) !== model[2]) begin
      errorCount++;
      $display("[TB] FAIL bRelease: bvalid %b awready %b reg2 %h, required 0 1 %h",
               s_bvalid, s_awready, regOf(2), model[2]);
    end
    tick();
    s_awvalid = 1'b0;
    checkCount++;
    if (s_awready !== 1'b0 || s_bvalid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL secondAwBuffered: awready %b bvalid %b, required 0 0", s_awready, s_bvalid);
    end
    s_wdata  = d2;
    s_wstrb  = 4'hF;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    modelWrite(32'h14, d2, 4'hF);
    checkCount++;
    if (s_bvalid !== 1'b1 || regOf(5) !== model[5]) begin
      errorCount++;
      $display("[TB] FAIL secondWrite: bvalid %b reg5 %h, required 1 %h", s_bvalid, regOf(5), model[5]);
    end
    tick();
  endtask

  task automatic test_read_collision();
    logic [31:0] oldVal;
    logic [31:0] newVal;
    logic        holdBad;
    oldVal    = model[3];
    newVal    = $urandom;
    holdBad   = 1'b0;
    s_bready  = 1'b1;
    s_rready  = 1'b0;
    s_awaddr  = 32'h0C;
    s_awvalid = 1'b1;
    s_wdata   = newVal;
    s_wstrb   = 4'hF;
    s_wvalid  = 1'b1;
    s_araddr  = 32'h0C;
    s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_arvalid = 1'b0;
    modelWrite(32'h0C, newVal, 4'hF);
    checkCount++;
    if (s_rvalid !== 1'b1 || s_rdata !== oldVal || regOf(3) !== newVal) begin
      errorCount++;
      $display("[TB] FAIL readCollision: rvalid %b rdata %h reg3 %h, required 1 %h %h",
               s_rvalid, s_rdata, regOf(3), oldVal, newVal);
    end
    for (int c = 0; c < 4; c++) begin
      if (s_rvalid !== 1'b1 || s_rdata !== oldVal || s_arready !== 1'b0 || s_rresp !== 2'b00)
        holdBad = 1'b1;
      tick();
    end
    checkCount++;
    if (holdBad) begin
      errorCount++;
      $display("[TB] FAIL rStall: rvalid %b rdata %h arready %b, required 1 %h 0",
               s_rvalid, s_rdata, s_arready, oldVal);
    end
    s_rready = 1'b1;
    tick();
    checkCount++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL rRelease: rvalid %b arready %b, required 0 1", s_rvalid, s_arready);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic [31:0] rd;
    logic [1:0]  rr;
    d         = $urandom;
    s_rready  = 1'b0;
    s_bready  = 1'b1;
    s_wdata   = 32'hA5A5_5A5A;
    s_wstrb   = 4'hF;
    s_wvalid  = 1'b1;
    s_araddr  = 32'h0C;
    s_arvalid = 1'b1;
    tick();
    s_wvalid  = 1'b0;
    s_arvalid = 1'b0;
    checkCount++;
    if (s_wready !== 1'b0 || s_rvalid !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL preResetState: wready %b rvalid %b, required 0 1", s_wready, s_rvalid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < REG_NUM; i++) model[i] = '0;
    checkCount++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100 ||
        s_rdata !== 32'h0 || reg_out !== '0 || s_rresp !== 2'b00) begin
      errorCount++;
      $display("[TB] FAIL midReset: rdy %b bv %b rv %b rdata %h reg_out %h, required 111 0 0 0 0",
               {s_awready, s_wready, s_arready}, s_bvalid, s_rvalid, s_rdata, reg_out);
    end
    #2;
    rst_n = 1'b1;
    tick();
    s_awaddr  = 32'h10;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    checkCount++;
    if (s_bvalid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL staleWDropped: bvalid %b, required 0", s_bvalid);
    end
    s_wdata  = d;
    s_wstrb  = 4'hF;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    modelWrite(32'h10, d, 4'hF);
    checkCount++;
    if (s_bvalid !== 1'b1 || regOf(4) !== model[4]) begin
      errorCount++;
      $display("[TB] FAIL postResetWrite: bvalid %b reg4 %h, required 1 %h", s_bvalid, regOf(4), model[4]);
    end
    tick();
    axiRead(32'h10, rd, rr);
    checkCount++;
    if (rd !== model[4] || rr !== 2'b00) begin
      errorCount++;
      $display("[TB] FAIL postResetRead: rdata %h rresp %b, required %h 00", rd, rr, model[4]);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [1:0]  rr;
    int          wrBad;
    int          rdBad;
    wrBad = 0;
    rdBad = 0;
    for (int t = 0; t < 40; t++) begin
      addr = $urandom;
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
`ifdef AXI_REGS_SLVERR_EN
      addr[1:0] = 2'b00;
`endif
      axiWrite(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp);
      modelWrite(addr, data, strb);
      if (resp !== 2'b00) wrBad++;
      addr = $urandom;
`ifdef AXI_REGS_SLVERR_EN
      addr[1:0] = 2'b00;
`endif
      axiRead(addr, rd, rr);
      if (rd !== model[idxOf(addr)] || rr !== 2'b00) begin
        rdBad++;
        if (rdBad == 1)
          $display("[TB] FAIL randomReadData: addr %h rdata %h rresp %b, required %h 00",
                   addr, rd, rr, model[idxOf(addr)]);
      end
    end
    checkCount++;
    if (wrBad != 0) begin
      errorCount++;
      $display("[TB] FAIL randomBresp: %0d writes with non-OKAY bresp, required 0", wrBad);
    end
    checkCount++;
    if (rdBad != 0) begin
      errorCount++;
      $display("[TB] FAIL randomReads: %0d wrong reads, required 0", rdBad);
    end
    for (int i = 0; i < REG_NUM; i++) begin
      checkCount++;
      if (regOf(i) !== model[i]) begin
        errorCount++;
        $display("[TB] FAIL randomRegOut%0d: %h, required %h", i, regOf(i), model[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        hsW;
    int          bCount;
    int          rCount;
    int          rBad;
    logic [31:0] d;
    bCount    = 0;
    rCount    = 0;
    rBad      = 0;
    d         = $urandom;
    s_bready  = 1'b1;
    s_rready  = 1'b1;
    s_awaddr  = 32'h18;
    s_wdata   = d;
    s_wstrb   = 4'hF;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    s_araddr  = 32'h1C;
    s_arvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      hsW = s_awready && s_wready;
      tick();
      if (hsW) begin
        modelWrite(32'h18, s_wdata, 4'hF);
        d       = d + 32'h0101_0101;
        s_wdata = d;
      end
      if (s_bvalid) bCount++;
      if (s_rvalid) begin
        rCount++;
        if (s_rdata !== model[7]) rBad++;
      end
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_arvalid = 1'b0;
    tick();
    checkCount++;
    if (bCount != 10 || rCount != 10) begin
      errorCount++;
      $display("[TB] FAIL throughput: %0d B and %0d R cycles in 20, required 10 and 10", bCount, rCount);
    end
    checkCount++;
    if (rBad != 0 || regOf(6) !== model[6]) begin
      errorCount++;
      $display("[TB] FAIL backToBackData: bad reads %0d reg6 %h, required 0 %h", rBad, regOf(6), model[6]);
    end
  endtask

`ifdef AXI_REGS_SLVERR_EN
  task automatic test_slverr();
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [1:0]  rr;
    axiWrite(32'h06, $urandom, 4'hF, 0, 1, resp);
    checkCount++;
    if (resp !== 2'b10 || regOf(1) !== model[1]) begin
      errorCount++;
      $display("[TB] FAIL slverrWrite: bresp %b reg1 %h, required 10 %h", resp, regOf(1), model[1]);
    end
    axiRead(32'h01, rd, rr);
    checkCount++;
    if (rr !== 2'b10 || rd !== 32'h0) begin
      errorCount++;
      $display("[TB] FAIL slverrRead: rresp %b rdata %h, required 10 0", rr, rd);
    end
    axiRead(32'h00, rd, rr);
    checkCount++;
    if (rr !== 2'b00 || rd !== model[0]) begin
      errorCount++;
      $display("[TB] FAIL alignedRead: rresp %b rdata %h, required 00 %h", rr, rd, model[0]);
    end
  endtask
`endif

  initial begin
    checkCount = 0;
    errorCount = 0;
    test_reset();
    test_simultaneous_write();
    test_w_before_aw();
    test_bready_stall();
    test_read_collision();
    test_reset_midflight();
    test_random();
    test_back_to_back();
`ifdef AXI_REGS_SLVERR_EN
    test_slverr();
`endif
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite slave endpoint holding a bank of software-visible 32-bit control/status registers. It sits behind the interconnect's address decoder and answers on one slave port. It accepts write address/data on independent channels, applies byte strobes, and returns B and R responses with full valid/ready handshaking. Register contents are exported in parallel for peripheral control logic.

## Interface
- ADDR_WIDTH, 32, address width of AW/AR channels
- DATA_WIDTH, 32, data width; fixed at 32 (WSTRB is 4 bits)
- REG_NUM, 8, number of registers; power of two, 2..256
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- s_awaddr  input  ADDR_WIDTH  write address
- s_awvalid  input  1  write address valid
- s_awready  output  1  write address ready
- s_wdata  input  DATA_WIDTH  write data
- s_wstrb  input  DATA_WIDTH/8  byte enables; bit b covers wdata[8b+7:8b]
- s_wvalid  input  1  write data valid
- s_wready  output  1  write data ready
- s_bresp  output  2  write response (2'b00 OKAY, 2'b10 SLVERR)
- s_bvalid  output  1  write response valid
- s_bready  input  1  write response ready
- s_araddr  input  ADDR_WIDTH  read address
- s_arvalid  input  1  read address valid
- s_arready  output  1  read address ready
- s_rdata  output  DATA_WIDTH  read data
- s_rresp  output  2  read response
- s_rvalid  output  1  read data valid
- s_rready  input  1  read data ready
- reg_out  output  REG_NUM*DATA_WIDTH  register i on bits [32i+31:32i]

## Operation
- Register index is addr[$clog2(REG_NUM)+1:2]. Higher address bits are ignored, so addresses alias across the decoded window.
- Write path: one-entry AW buffer and one-entry W buffer.
  - s_awready = !aw_full && !s_bvalid.
  - s_wready = !w_full && !s_bvalid.
  - An AW handshake fills the AW buffer. A W handshake fills the W buffer.
- Write commit happens at the first rising edge where both address and data are present, each either buffered or handshaking in that cycle.
  - At that edge, bytes with wstrb=1 are written into the selected register and bytes with wstrb=0 are unchanged.
  - Both buffers clear at that edge, and s_bvalid rises with its bresp.
- s_bvalid and s_bresp hold until the s_bvalid && s_bready edge, then s_bvalid drops. No new AW/W handshake is accepted while s_bvalid=1.
- Read path: s_arready = !s_rvalid.
  - On an AR handshake edge, s_rdata is loaded from the selected register and s_rvalid rises.
  - s_rdata, s_rresp and s_rvalid hold until the s_rready edge.
- Read and write paths are independent. A read handshaking on the same edge as a write commit to the same register returns the pre-write value.
- Response is always OKAY unless the Configuration feature flags an error.
- Reset (rst_n=0, at any time, including mid-transaction):
  - all registers are 0; reg_out=0
  - both buffers are empty
  - s_bvalid=0, s_rvalid=0, s_bresp=2'b00, s_rresp=2'b00, s_rdata=0
  - s_awready=s_wready=s_arready=1
  - in-flight transactions are dropped with no response

## Timing
- Ready outputs are combinational from internal state only. They have no dependency on the valid inputs.
- Minimum write latency: AW and W handshake together on edge N, which is also the commit edge, so s_bvalid=1 from cycle N+1. reg_out updates on the same edge.
- AW before W (or W before AW) by k cycles: commit occurs at the later handshake edge.
- Minimum read latency: AR handshake on edge N gives s_rvalid=1 from cycle N+1.
- Sustained throughput with bready=rready=1 is one write every 2 cycles and one read every 2 cycles, running concurrently.

## Configuration
- AXI_REGS_SLVERR_EN defined:
  - A write whose awaddr[1:0] is not 0 commits no bytes and returns bresp=SLVERR.
  - A read whose araddr[1:0] is not 0 returns rdata=0 and rresp=SLVERR.
- AXI_REGS_SLVERR_EN undefined: addr[1:0] is ignored, every access returns OKAY, and there is no error logic.

## Test plan
- Simultaneous AW=0x0C and W=0xDEADBEEF with wstrb=4'hF, bready=1 -> s_bvalid is high for exactly 1 cycle starting in the cycle after the handshake; bresp=OKAY; reg_out[127:96]=0xDEADBEEF.
- W=0x11223344 with wstrb=4'b0101 to reg 1 (prior value 0xFFFFFFFF), W presented 3 cycles before AW -> s_wready=0 after the W handshake; commit at the AW edge; reg1=0xFF22FF44.
- bready held 0 for 5 cycles after a write -> s_bvalid and bresp stable; s_awready=s_wready=0 throughout; a second AW is accepted only after the B handshake.
- Read reg 3 with rready low for 4 cycles -> rdata stable; arready=0; a concurrent write commit to reg 3 on the AR edge returns the old value.
- Assert rst_n=0 while W is buffered and s_rvalid=1 -> all outputs reach their reset values immediately; after release, a new write completes normally.
- With AXI_REGS_SLVERR_EN: write to 0x06 -> bresp=2'b10 and the register is unchanged; read from 0x01 -> rresp=2'b10 and rdata=0.
